// File: rtl/pipeline_pkg.sv
// Shared definitions for the forwarding pipeline: opcodes, instruction field
// positions, forwarding selects and the per-stage control latch.
package pipeline_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_LOAD  = 4'h3;
  localparam logic [3:0] OP_STORE = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_BNEZ  = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int RS_HI = 11;
  localparam int RS_LO = 8;
  localparam int RT_HI = 7;
  localparam int RT_LO = 4;
  localparam int RD_HI = 3;
  localparam int RD_LO = 0;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_EX = 2'd1,
    FWD_WB = 2'd2
  } fwd_sel_e;

  // Control part of a stage latch; the top wraps it with the DATA_W-wide
  // a/b/result fields because their width is a module parameter.
  typedef struct packed {
    logic       valid;
    logic [3:0] op;
    logic [3:0] rs;
    logic [3:0] rt;
    logic [3:0] rd;
  } stage_ctrl_t;

  function automatic stage_ctrl_t decode(input logic [15:0] instr);
    stage_ctrl_t c;
    c.valid = 1'b0;
    c.rs    = instr[RS_HI:RS_LO];
    c.rt    = instr[RT_HI:RT_LO];
    c.rd    = instr[RD_HI:RD_LO];
    case (instr[OP_HI:OP_LO])
      OP_ADD, OP_SUB, OP_LOAD, OP_STORE,
      OP_AND, OP_OR, OP_BNEZ, OP_HALT: c.op = instr[OP_HI:OP_LO];
      default:                         c.op = OP_NOP;
    endcase
    return c;
  endfunction

  function automatic logic is_alu(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic writes_rf(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_LOAD: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic reads_rs(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_LOAD, OP_STORE, OP_BNEZ: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  function automatic logic reads_rt(input logic [3:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_STORE: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_hazard_unit.sv
// Forwarding-source selection for the ID operands, taken-branch flush, and
// the one-cycle-ahead load-use stall prediction.
module pipeline_hazard_unit
  import pipeline_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  stage_ctrl_t       id_ctl,
  input  stage_ctrl_t       ex_ctl,
  input  stage_ctrl_t       wb_ctl,
  input  logic [DATA_W-1:0] ex_a,
  input  stage_ctrl_t       fetch_ctl,
  input  logic              stall_now,
  output fwd_sel_e          fwd_a_sel,
  output fwd_sel_e          fwd_b_sel,
  output logic              flush,
  output logic              stall_next
);

  logic ex_fwd_ok_s;
  logic wb_fwd_ok_s;
  logic next_uses_load_s;

  // Operand source priority: EX (ALU only), then WB, then register file.
  always_comb begin
    ex_fwd_ok_s = ex_ctl.valid && is_alu(ex_ctl.op);
    wb_fwd_ok_s = wb_ctl.valid && writes_rf(wb_ctl.op);

    if (ex_fwd_ok_s && (ex_ctl.rd == id_ctl.rs)) begin
      fwd_a_sel = FWD_EX;
    end else if (wb_fwd_ok_s && (wb_ctl.rd == id_ctl.rs)) begin
      fwd_a_sel = FWD_WB;
    end else begin
      fwd_a_sel = FWD_RF;
    end

    if (ex_fwd_ok_s && (ex_ctl.rd == id_ctl.rt)) begin
      fwd_b_sel = FWD_EX;
    end else if (wb_fwd_ok_s && (wb_ctl.rd == id_ctl.rt)) begin
      fwd_b_sel = FWD_WB;
    end else begin
      fwd_b_sel = FWD_RF;
    end
  end

  // The LOAD now in ID reaches EX next cycle exactly when the word being
  // fetched reaches ID, so the stall can be decided a cycle early.
  always_comb begin
    flush = ex_ctl.valid && (ex_ctl.op == OP_BNEZ) && (ex_a != {DATA_W{1'b0}});

    next_uses_load_s =
      (reads_rs(fetch_ctl.op) && (fetch_ctl.rs == id_ctl.rd)) ||
      (reads_rt(fetch_ctl.op) && (fetch_ctl.rt == id_ctl.rd));

    if (!stall_now && !flush && fetch_ctl.valid &&
        id_ctl.valid && (id_ctl.op == OP_LOAD)) begin
      stall_next = next_uses_load_s;
    end else begin
      stall_next = 1'b0;
    end
  end

endmodule

// File: rtl/pipeline_processor_fwd.sv
// Four-stage (IF/ID/EX/WB) in-order CPU with full forwarding, load-use stall,
// taken-branch flush and HALT. Register file and memories are inline arrays.
module pipeline_processor_fwd
  import pipeline_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int IMEM_DEPTH = 256,
  parameter int DMEM_DEPTH = 256,
  parameter int PC_W       = 8
) (
  input  logic            clk,
  input  logic            reset,
  output logic            halted,
  output logic [PC_W-1:0] pc_out,
  output logic [31:0]     retired_count,
  output logic            stall_out
);

  localparam int IA_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DA_W = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam int MW   = (DATA_W > 32) ? DATA_W : 32;

  typedef struct packed {
    stage_ctrl_t       ctl;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] result;
  } stage_t;

  logic [15:0]       instruction_memory [0:IMEM_DEPTH-1];
  logic [DATA_W-1:0] data_memory        [0:DMEM_DEPTH-1];
  logic [DATA_W-1:0] registers          [0:15];

  logic [PC_W-1:0] pc_r;
  stage_ctrl_t     ifid_r;
  stage_t          idex_r;
  stage_t          exwb_r;
  logic            halted_r;
  logic            halt_seen_r;
  logic            stall_r;
  logic [31:0]     retired_r;

  logic [15:0]       fetch_word_s;
  stage_ctrl_t       fetch_ctl_s;
  logic              fetch_en_s;
  logic              halt_decode_s;
  logic [PC_W-1:0]   pc_inc_s;
  logic [PC_W-1:0]   branch_tgt_s;
  logic [31:0]       tgt_wide_s;
  fwd_sel_e          fwd_a_sel_s;
  fwd_sel_e          fwd_b_sel_s;
  logic              flush_s;
  logic              stall_next_s;
  logic [DATA_W-1:0] id_a_s;
  logic [DATA_W-1:0] id_b_s;
  logic [DATA_W-1:0] ex_alu_s;
  logic [DATA_W-1:0] ex_result_s;
  logic [MW-1:0]     a_wide_s;
  logic [DA_W-1:0]   dmem_idx_s;
  logic              retire_s;
  logic              unused_fields_s;

  assign halted        = halted_r;
  assign pc_out        = pc_r;
  assign retired_count = retired_r;
  assign stall_out     = stall_r;

  assign unused_fields_s = ^{idex_r.ctl.rs, idex_r.ctl.rt, idex_r.result,
                             exwb_r.ctl.rs, exwb_r.ctl.rt, exwb_r.a, exwb_r.b};

  pipeline_hazard_unit #(.DATA_W(DATA_W)) u_hazard (
    .id_ctl     (ifid_r),
    .ex_ctl     (idex_r.ctl),
    .wb_ctl     (exwb_r.ctl),
    .ex_a       (idex_r.a),
    .fetch_ctl  (fetch_ctl_s),
    .stall_now  (stall_r),
    .fwd_a_sel  (fwd_a_sel_s),
    .fwd_b_sel  (fwd_b_sel_s),
    .flush      (flush_s),
    .stall_next (stall_next_s)
  );

  // Fetch: PC increment with wrap, HALT-driven fetch stop, branch target.
  always_comb begin
    fetch_word_s  = instruction_memory[IA_W'(pc_r)];
    halt_decode_s = ifid_r.valid && (ifid_r.op == OP_HALT) && !flush_s;
    fetch_en_s    = !halted_r && !halt_seen_r && !halt_decode_s && !stall_r && !flush_s;
    fetch_ctl_s       = decode(fetch_word_s);
    fetch_ctl_s.valid = fetch_en_s;
    if (pc_r == PC_W'(IMEM_DEPTH - 1)) begin
      pc_inc_s = {PC_W{1'b0}};
    end else begin
      pc_inc_s = pc_r + PC_W'(32'd1);
    end
    tgt_wide_s   = 32'({idex_r.ctl.rt, idex_r.ctl.rd}) % 32'(IMEM_DEPTH);
    branch_tgt_s = PC_W'(tgt_wide_s);
  end

  // ID operand muxes; WB forwarding also realises the write-first register file.
  always_comb begin
    case (fwd_a_sel_s)
      FWD_EX:  id_a_s = ex_alu_s;
      FWD_WB:  id_a_s = exwb_r.result;
      default: id_a_s = registers[ifid_r.rs];
    endcase
    case (fwd_b_sel_s)
      FWD_EX:  id_b_s = ex_alu_s;
      FWD_WB:  id_b_s = exwb_r.result;
      default: id_b_s = registers[ifid_r.rt];
    endcase
  end

  // EX: ALU, data-memory address and the value latched into EX/WB.
  always_comb begin
    case (idex_r.ctl.op)
      OP_ADD:  ex_alu_s = idex_r.a + idex_r.b;
      OP_SUB:  ex_alu_s = idex_r.a - idex_r.b;
      OP_AND:  ex_alu_s = idex_r.a & idex_r.b;
      OP_OR:   ex_alu_s = idex_r.a | idex_r.b;
      default: ex_alu_s = {DATA_W{1'b0}};
    endcase
    a_wide_s   = MW'(idex_r.a);
    dmem_idx_s = DA_W'(a_wide_s % MW'(DMEM_DEPTH));
    if (idex_r.ctl.op == OP_LOAD) begin
      ex_result_s = data_memory[dmem_idx_s];
    end else begin
      ex_result_s = ex_alu_s;
    end
    retire_s = exwb_r.ctl.valid && (exwb_r.ctl.op != OP_NOP);
  end

  // Pipeline advance; once halted nothing changes until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_r             <= {PC_W{1'b0}};
      ifid_r.valid     <= 1'b0;
      idex_r.ctl.valid <= 1'b0;
      exwb_r.ctl.valid <= 1'b0;
      halted_r         <= 1'b0;
      halt_seen_r      <= 1'b0;
      stall_r          <= 1'b0;
      retired_r        <= 32'd0;
    end else if (!halted_r) begin
      if (exwb_r.ctl.valid && writes_rf(exwb_r.ctl.op)) begin
        registers[exwb_r.ctl.rd] <= exwb_r.result;
      end
      if (exwb_r.ctl.valid && (exwb_r.ctl.op == OP_HALT)) begin
        halted_r <= 1'b1;
      end
      if (retire_s) begin
        retired_r <= retired_r + 32'd1;
      end

      if (idex_r.ctl.valid && (idex_r.ctl.op == OP_STORE)) begin
        data_memory[dmem_idx_s] <= idex_r.b;
      end
      exwb_r <= '{ctl: idex_r.ctl, a: idex_r.a, b: idex_r.b, result: ex_result_s};

      if (flush_s || stall_r) begin
        idex_r.ctl.valid <= 1'b0;
      end else begin
        idex_r <= '{ctl: ifid_r, a: id_a_s, b: id_b_s, result: {DATA_W{1'b0}}};
      end

      if (flush_s) begin
        ifid_r.valid <= 1'b0;
        pc_r         <= branch_tgt_s;
      end else if (stall_r) begin
        ifid_r <= ifid_r;
      end else if (fetch_en_s) begin
        ifid_r <= fetch_ctl_s;
        pc_r   <= pc_inc_s;
      end else begin
        ifid_r.valid <= 1'b0;
      end

      if (halt_decode_s) begin
        halt_seen_r <= 1'b1;
      end
      stall_r <= stall_next_s;
    end
  end

endmodule
